vga_capture_receiver: RTL and testbench
=======================================

Name: vga_capture_receiver

Overview:
- Sink end of the VGA link: samples Hsync, Vsync and 12-bit RGB from a VGA source on a single clock, qualified by a pixel sample strobe.
- Measures line and frame timing, locks to the expected mode (default 800x600@72), then emits visible pixels with x/y coordinates on a write interface for a frame buffer or checker.
- Sits downstream of the VGA timing generator: in loopback, or fed from an external source.

Parameters:
- HORIZONTAL_VISIBLE_AREA, 800, visible pixels per line
- HORIZONTAL_BACK_PORCH, 64, samples from line start (sync end) to first visible pixel
- HORIZONTAL_SYNC_PULSE, 120, expected Hsync pulse width in samples
- WHOLE_LINE, 1040, expected samples per line
- VERTICAL_VISIBLE_AREA, 600, visible lines per frame
- VERTICAL_BACK_PORCH, 23, lines from frame start to first visible line
- WHOLE_FRAME, 666, expected lines per frame
- CNT_W, 12, width of all internal counters and measurement outputs

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous active-high reset
- pixel_enable  in  1  one-cycle sample strobe, one per source pixel
- Hsync  in  1  horizontal sync, active-low pulse
- Vsync  in  1  vertical sync, active-low pulse
- Red_in, Green_in, Blue_in  in  4 each  source colour
- pixel_valid  out  1  one-cycle strobe, visible pixel on outputs
- pixel_x  out  CNT_W  visible column, 0..HORIZONTAL_VISIBLE_AREA-1
- pixel_y  out  CNT_W  visible row, 0..VERTICAL_VISIBLE_AREA-1
- Red_out, Green_out, Blue_out  out  4 each  captured colour
- frame_start  out  1  coincident with pixel_valid at (0,0)
- locked  out  1  high in LOCKED state
- no_signal  out  1  high while no Hsync edge within 2*WHOLE_LINE samples
- measured_line  out  CNT_W  last measured samples per line
- measured_frame  out  CNT_W  last measured lines per frame
- error_count  out  8  saturating count of LOCKED->SEARCH drops

Behaviour:
- All state advances only on cycles with pixel_enable=1. Inputs are registered once on enable (stage S0). Edge detection is performed on S0 versus the previous sample.
- Line start (ls): sample where Hsync=1 and the previous Hsync=0.
  - At ls: h_cnt<=0, measured_line<=h_cnt+1.
  - Otherwise h_cnt increments, saturating at all-ones.
  - h_pulse counts Hsync=0 samples, is cleared at ls, and is compared at ls.
- Vertical:
  - vs_seen sets when Vsync=0 is sampled.
  - At ls with Vsync=1 and vs_seen=1 (frame start, fs): v_cnt<=0, measured_frame<=v_cnt+1, vs_seen<=0.
  - Other ls: v_cnt+1, saturating.
- Line OK: measured line equals WHOLE_LINE and pulse width equals HORIZONTAL_SYNC_PULSE. Frame OK: measured frame equals WHOLE_FRAME and every line in the frame was OK.
- FSM (reset state SEARCH):
  - SEARCH -> VERIFY at fs with frame OK.
  - VERIFY -> LOCKED at next fs with frame OK, else -> SEARCH.
  - LOCKED -> SEARCH at any ls with line not OK, at fs with frame not OK, or on timeout. Each such drop increments error_count, saturating at 255.
  - Timeout from any state -> SEARCH.
- Timeout: sample counter since last ls reaches 2*WHOLE_LINE. Sets no_signal=1 and clears it at next ls.
- Capture (LOCKED only):
  - Condition: h_cnt in [HORIZONTAL_BACK_PORCH, +HORIZONTAL_VISIBLE_AREA) and v_cnt in [VERTICAL_BACK_PORCH, +VERTICAL_VISIBLE_AREA).
  - When true: pixel_valid=1 one clock after the sample, pixel_x=h_cnt-HORIZONTAL_BACK_PORCH, pixel_y=v_cnt-VERTICAL_BACK_PORCH, colour = sampled RGB.
  - Latency: 2 clocks from Hsync/RGB at port to pixel_valid (S0 plus output register).
- Outputs:
  - When pixel_valid=0, Red_out/Green_out/Blue_out are driven 0 and pixel_x/pixel_y hold their last values.
  - The transition into LOCKED happens at an fs; capture begins with the next visible pixel, so the first frame_start is the first (0,0).
- Simultaneous events: a timeout and an ls on the same sample are resolved as ls (timeout counter cleared). A lock drop takes effect on the same sample, so that sample produces no pixel.
- Reset (any time, async): state SEARCH, all counters 0, vs_seen=0. All outputs 0, except no_signal=0 and measured_* = 0.

Decomposition:
- Shared package vga_pkg: default timing constants for 800x600@72, also used by the timing generator, plus the state enum {SEARCH, VERIFY, LOCKED}.
- One sub-module is natural: vga_sync_measure, which does S0 registering, edge detection, h/v counters, measurements and the timeout, and emits ls, fs, line_ok and frame_ok.
- The top level holds the FSM and the capture register.

Test Plan:
- Loopback, generator at defaults, pixel_enable every 2nd clock: locked=1 after the second fs. Then exactly 480000 pixel_valid per frame, frame_start once, last pixel (799,599), RGB matches source.
- Line length 1041 in one line while LOCKED: locked drops at that ls, error_count=1, relock after 2 good frames.
- Hsync held high for 2080 samples: no_signal=1, locked=0; next valid Hsync pulse clears no_signal.
- Frame of 665 lines: measured_frame=665, stays in SEARCH; no pixel_valid.
- Reset asserted mid-frame while LOCKED: all outputs 0 immediately, state SEARCH; relock after 2 frames.
- Pixel at h_cnt=63 or 864, v_cnt=22 or 623: no pixel_valid; h_cnt=64, v_cnt=23: pixel (0,0) with frame_start=1.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA timing defaults (800x600@72) and the receiver lock-state encoding.
package vga_pkg;

  localparam int unsigned VGA_H_VISIBLE    = 800;
  localparam int unsigned VGA_H_BACK_PORCH = 64;
  localparam int unsigned VGA_H_SYNC_PULSE = 120;
  localparam int unsigned VGA_WHOLE_LINE   = 1040;
  localparam int unsigned VGA_V_VISIBLE    = 600;
  localparam int unsigned VGA_V_BACK_PORCH = 23;
  localparam int unsigned VGA_WHOLE_FRAME  = 666;
  localparam int unsigned VGA_CNT_W        = 12;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } rx_state_t;

endpackage

// File: rtl/vga_sync_measure.sv
// Sample-stage registering, sync edge detection, h/v position counters,
// line/frame measurement and the no-signal timeout for the VGA receiver.
module vga_sync_measure
  import vga_pkg::*;
#(
  parameter int unsigned HORIZONTAL_SYNC_PULSE = VGA_H_SYNC_PULSE,
  parameter int unsigned WHOLE_LINE            = VGA_WHOLE_LINE,
  parameter int unsigned WHOLE_FRAME           = VGA_WHOLE_FRAME,
  parameter int unsigned CNT_W                 = VGA_CNT_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             pixel_enable,
  input  logic             Hsync,
  input  logic             Vsync,
  input  logic [3:0]       Red_in,
  input  logic [3:0]       Green_in,
  input  logic [3:0]       Blue_in,
  output logic             sample_valid,
  output logic             line_start,
  output logic             frame_begin,
  output logic             line_ok,
  output logic             frame_ok,
  output logic             timeout,
  output logic [CNT_W-1:0] h_now,
  output logic [CNT_W-1:0] v_now,
  output logic [3:0]       red_s0,
  output logic [3:0]       green_s0,
  output logic [3:0]       blue_s0,
  output logic             no_signal,
  output logic [CNT_W-1:0] measured_line,
  output logic [CNT_W-1:0] measured_frame
);

  localparam logic [CNT_W-1:0] LINE_LEN  = CNT_W'(WHOLE_LINE);
  localparam logic [CNT_W-1:0] PULSE_LEN = CNT_W'(HORIZONTAL_SYNC_PULSE);
  localparam logic [CNT_W-1:0] FRAME_LEN = CNT_W'(WHOLE_FRAME);
  localparam logic [CNT_W-1:0] TO_LIMIT  = CNT_W'(2 * WHOLE_LINE);

  logic             hs_s0, vs_s0, hs_prev, vs_seen, lines_ok;
  logic [CNT_W-1:0] h_cnt, v_cnt, h_pulse, to_cnt;
  logic [CNT_W-1:0] line_len, frame_len, h_inc, v_inc;

  // The processing stage runs one clock after each strobe, on the S0 copy.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sample_valid <= 1'b0;
      hs_s0        <= 1'b0;
      vs_s0        <= 1'b0;
      red_s0       <= '0;
      green_s0     <= '0;
      blue_s0      <= '0;
    end else begin
      sample_valid <= pixel_enable;
      if (pixel_enable) begin
        hs_s0    <= Hsync;
        vs_s0    <= Vsync;
        red_s0   <= Red_in;
        green_s0 <= Green_in;
        blue_s0  <= Blue_in;
      end
    end
  end

  always_comb begin
    line_len    = h_cnt + 1'b1;
    frame_len   = v_cnt + 1'b1;
    h_inc       = (h_cnt == '1) ? h_cnt : line_len;
    v_inc       = (v_cnt == '1) ? v_cnt : frame_len;
    line_start  = sample_valid && hs_s0 && !hs_prev;
    frame_begin = line_start && vs_s0 && vs_seen;
    line_ok     = (line_len == LINE_LEN) && (h_pulse == PULSE_LEN);
    frame_ok    = (frame_len == FRAME_LEN) && lines_ok && line_ok;
    // A line start on the same sample wins over the timeout.
    timeout     = sample_valid && !line_start && (to_cnt == TO_LIMIT - 1'b1);
    h_now       = line_start ? '0 : h_inc;
    v_now       = frame_begin ? '0 : (line_start ? v_inc : v_cnt);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hs_prev        <= 1'b0;
      vs_seen        <= 1'b0;
      lines_ok       <= 1'b1;
      h_cnt          <= '0;
      v_cnt          <= '0;
      h_pulse        <= '0;
      to_cnt         <= '0;
      no_signal      <= 1'b0;
      measured_line  <= '0;
      measured_frame <= '0;
    end else if (sample_valid) begin
      hs_prev <= hs_s0;
      h_cnt   <= h_now;
      v_cnt   <= v_now;
      if (line_start) begin
        measured_line <= line_len;
        h_pulse       <= '0;
        to_cnt        <= '0;
        no_signal     <= 1'b0;
        lines_ok      <= frame_begin ? 1'b1 : (lines_ok && line_ok);
      end else begin
        if (!hs_s0 && h_pulse != '1) h_pulse <= h_pulse + 1'b1;
        if (to_cnt != TO_LIMIT) to_cnt <= to_cnt + 1'b1;
        if (timeout) no_signal <= 1'b1;
      end
      if (frame_begin) begin
        measured_frame <= frame_len;
        vs_seen        <= 1'b0;
      end else if (!vs_s0) begin
        vs_seen <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/vga_capture_receiver.sv
// VGA sink: locks to the configured mode via the sync measurement block and
// emits visible pixels with coordinates while LOCKED.
module vga_capture_receiver
  import vga_pkg::*;
#(
  parameter int unsigned HORIZONTAL_VISIBLE_AREA = VGA_H_VISIBLE,
  parameter int unsigned HORIZONTAL_BACK_PORCH   = VGA_H_BACK_PORCH,
  parameter int unsigned HORIZONTAL_SYNC_PULSE   = VGA_H_SYNC_PULSE,
  parameter int unsigned WHOLE_LINE              = VGA_WHOLE_LINE,
  parameter int unsigned VERTICAL_VISIBLE_AREA   = VGA_V_VISIBLE,
  parameter int unsigned VERTICAL_BACK_PORCH     = VGA_V_BACK_PORCH,
  parameter int unsigned WHOLE_FRAME             = VGA_WHOLE_FRAME,
  parameter int unsigned CNT_W                   = VGA_CNT_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             pixel_enable,
  input  logic             Hsync,
  input  logic             Vsync,
  input  logic [3:0]       Red_in,
  input  logic [3:0]       Green_in,
  input  logic [3:0]       Blue_in,
  output logic             pixel_valid,
  output logic [CNT_W-1:0] pixel_x,
  output logic [CNT_W-1:0] pixel_y,
  output logic [3:0]       Red_out,
  output logic [3:0]       Green_out,
  output logic [3:0]       Blue_out,
  output logic             frame_start,
  output logic             locked,
  output logic             no_signal,
  output logic [CNT_W-1:0] measured_line,
  output logic [CNT_W-1:0] measured_frame,
  output logic [7:0]       error_count
);

  localparam logic [CNT_W-1:0] H_FIRST = CNT_W'(HORIZONTAL_BACK_PORCH);
  localparam logic [CNT_W-1:0] H_END   = CNT_W'(HORIZONTAL_BACK_PORCH + HORIZONTAL_VISIBLE_AREA);
  localparam logic [CNT_W-1:0] V_FIRST = CNT_W'(VERTICAL_BACK_PORCH);
  localparam logic [CNT_W-1:0] V_END   = CNT_W'(VERTICAL_BACK_PORCH + VERTICAL_VISIBLE_AREA);

  logic             sample_valid, line_start, frame_begin, line_ok, frame_ok, timeout;
  logic [CNT_W-1:0] h_now, v_now;
  logic [3:0]       red_s0, green_s0, blue_s0;
  rx_state_t        state, state_nxt;
  logic             lock_drop, capture;

  vga_sync_measure #(
    .HORIZONTAL_SYNC_PULSE(HORIZONTAL_SYNC_PULSE),
    .WHOLE_LINE           (WHOLE_LINE),
    .WHOLE_FRAME          (WHOLE_FRAME),
    .CNT_W                (CNT_W)
  ) u_measure (
    .clock         (clock),
    .reset         (reset),
    .pixel_enable  (pixel_enable),
    .Hsync         (Hsync),
    .Vsync         (Vsync),
    .Red_in        (Red_in),
    .Green_in      (Green_in),
    .Blue_in       (Blue_in),
    .sample_valid  (sample_valid),
    .line_start    (line_start),
    .frame_begin   (frame_begin),
    .line_ok       (line_ok),
    .frame_ok      (frame_ok),
    .timeout       (timeout),
    .h_now         (h_now),
    .v_now         (v_now),
    .red_s0        (red_s0),
    .green_s0      (green_s0),
    .blue_s0       (blue_s0),
    .no_signal     (no_signal),
    .measured_line (measured_line),
    .measured_frame(measured_frame)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= SEARCH;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      SEARCH:  if (frame_begin && frame_ok) state_nxt = VERIFY;
      VERIFY:  if (frame_begin) state_nxt = frame_ok ? LOCKED : SEARCH;
      LOCKED:  if ((line_start && !line_ok) || (frame_begin && !frame_ok)) state_nxt = SEARCH;
      default: state_nxt = SEARCH;
    endcase
    if (timeout) state_nxt = SEARCH;
    lock_drop = (state == LOCKED) && (state_nxt == SEARCH);
    // Gating on the next state makes a drop suppress its own sample.
    capture   = sample_valid && (state == LOCKED) && (state_nxt == LOCKED) &&
                (h_now >= H_FIRST) && (h_now < H_END) &&
                (v_now >= V_FIRST) && (v_now < V_END);
  end

  assign locked = (state == LOCKED);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pixel_valid <= 1'b0;
      frame_start <= 1'b0;
      pixel_x     <= '0;
      pixel_y     <= '0;
      Red_out     <= '0;
      Green_out   <= '0;
      Blue_out    <= '0;
      error_count <= '0;
    end else begin
      pixel_valid <= capture;
      frame_start <= capture && (h_now == H_FIRST) && (v_now == V_FIRST);
      if (capture) begin
        pixel_x   <= h_now - H_FIRST;
        pixel_y   <= v_now - V_FIRST;
        Red_out   <= red_s0;
        Green_out <= green_s0;
        Blue_out  <= blue_s0;
      end else begin
        Red_out   <= '0;
        Green_out <= '0;
        Blue_out  <= '0;
      end
      if (lock_drop && error_count != '1) error_count <= error_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_vga_capture_receiver.sv
// Scoreboard bench for vga_capture_receiver on a reduced video mode with a
// line-level source generator and a frame/line reference model.
module tb_vga_capture_receiver;

  localparam int H_VIS = 16;
  localparam int H_BP  = 4;
  localparam int H_SP  = 6;
  localparam int WL    = 32;
  localparam int V_VIS = 8;
  localparam int V_BP  = 3;
  localparam int WF    = 16;
  localparam int CW    = 12;

  typedef enum int {M_SEARCH, M_VERIFY, M_LOCKED} mode_t;
  typedef struct {
    int         x;
    int         y;
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } pix_t;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          pixel_enable = 1'b0;
  logic          Hsync = 1'b1;
  logic          Vsync = 1'b1;
  logic [3:0]    Red_in = '0, Green_in = '0, Blue_in = '0;
  logic          pixel_valid, frame_start, locked, no_signal;
  logic [CW-1:0] pixel_x, pixel_y, measured_line, measured_frame;
  logic [3:0]    Red_out, Green_out, Blue_out;
  logic [7:0]    error_count;

  int   tests = 0;
  int   fails = 0;
  pix_t expq[$];
  int   fs_seen = 0;
  int   fs_expected = 0;

  mode_t m_state;
  int    m_err, m_meas_line, m_meas_frame, m_row, p_len;
  bit    m_nosig, m_vseen, m_all_ok, m_frame_full, p_full;

  vga_capture_receiver #(
    .HORIZONTAL_VISIBLE_AREA(H_VIS),
    .HORIZONTAL_BACK_PORCH  (H_BP),
    .HORIZONTAL_SYNC_PULSE  (H_SP),
    .WHOLE_LINE             (WL),
    .VERTICAL_VISIBLE_AREA  (V_VIS),
    .VERTICAL_BACK_PORCH    (V_BP),
    .WHOLE_FRAME            (WF),
    .CNT_W                  (CW)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .pixel_enable  (pixel_enable),
    .Hsync         (Hsync),
    .Vsync         (Vsync),
    .Red_in        (Red_in),
    .Green_in      (Green_in),
    .Blue_in       (Blue_in),
    .pixel_valid   (pixel_valid),
    .pixel_x       (pixel_x),
    .pixel_y       (pixel_y),
    .Red_out       (Red_out),
    .Green_out     (Green_out),
    .Blue_out      (Blue_out),
    .frame_start   (frame_start),
    .locked        (locked),
    .no_signal     (no_signal),
    .measured_line (measured_line),
    .measured_frame(measured_frame),
    .error_count   (error_count)
  );

  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  // Monitor: every presented pixel is matched against the oldest expectation.
  always @(negedge clock) begin
    pix_t e;
    if (!reset && frame_start) fs_seen++;
    if (!reset && pixel_valid) begin
      tests++;
      if (expq.size() == 0) begin
        fails++;
        $display("FAIL unexpected_pixel: got (%0d,%0d) expected no pixel", pixel_x, pixel_y);
      end else begin
        e = expq.pop_front();
        if (pixel_x !== CW'(e.x) || pixel_y !== CW'(e.y) || Red_out !== e.r ||
            Green_out !== e.g || Blue_out !== e.b ||
            frame_start !== (e.x == 0 && e.y == 0)) begin
          fails++;
          $display("FAIL pixel: got (%0d,%0d) rgb=%h%h%h fs=%b expected (%0d,%0d) rgb=%h%h%h fs=%b",
                   pixel_x, pixel_y, Red_out, Green_out, Blue_out, frame_start,
                   e.x, e.y, e.r, e.g, e.b, (e.x == 0 && e.y == 0));
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_state = M_SEARCH; m_err = 0; m_nosig = 0;
    m_meas_line = 0; m_meas_frame = 0;
    m_vseen = 0; m_row = 0; m_all_ok = 1; m_frame_full = 0;
    p_full = 0; p_len = 0;
  endtask

  task automatic model_drop();
    if (m_state == M_LOCKED && m_err < 255) m_err++;
    m_state = M_SEARCH;
  endtask

  task automatic drive_sample(input logic hs, input logic vs,
                              input logic [3:0] r, input logic [3:0] g, input logic [3:0] b);
    int unsigned gap;
    gap = $urandom_range(2);
    pixel_enable = 1'b1;
    Hsync = hs; Vsync = vs; Red_in = r; Green_in = g; Blue_in = b;
    @(posedge clock); #1;
    pixel_enable = 1'b0;
    repeat (gap) begin @(posedge clock); #1; end
  endtask

  task automatic settle_and_check();
    repeat (2) begin @(posedge clock); #1; end
    check("locked", int'(locked), int'(m_state == M_LOCKED));
    check("no_signal", int'(no_signal), int'(m_nosig));
    check("error_count", int'(error_count), m_err);
    if (m_meas_line >= 0) check("measured_line", int'(measured_line), m_meas_line);
    if (m_meas_frame >= 0) check("measured_frame", int'(measured_frame), m_meas_frame);
    check("idle_outputs", int'({pixel_valid, Red_out, Green_out, Blue_out}), 0);
  endtask

  // Line boundary seen by the receiver: judge the line (and frame) just ended.
  task automatic ls_event(input bit vs_low);
    bit ok, fok;
    ok = p_full && (p_len == WL);
    m_meas_line = p_full ? p_len : -1;
    m_nosig = 0;
    if (m_vseen && !vs_low) begin
      fok = m_frame_full && m_all_ok && ok && (m_row + 1 == WF);
      m_meas_frame = m_frame_full ? m_row + 1 : -1;
      case (m_state)
        M_SEARCH: if (fok) m_state = M_VERIFY;
        M_VERIFY: m_state = fok ? M_LOCKED : M_SEARCH;
        default:  if (!fok) model_drop();
      endcase
      m_vseen = 0; m_row = 0; m_all_ok = 1; m_frame_full = 1;
    end else begin
      if (m_state == M_LOCKED && !ok) model_drop();
      m_row++;
      m_all_ok = m_all_ok && ok;
    end
  endtask

  task automatic gen_line(input int len, input bit vs_low);
    logic [3:0] r, g, b;
    pix_t p;
    ls_event(vs_low);
    for (int h = 0; h < len; h++) begin
      r = 4'($urandom); g = 4'($urandom); b = 4'($urandom);
      if (h == 2 * WL) begin
        model_drop();
        m_nosig = 1;
      end
      if (m_state == M_LOCKED && h >= H_BP && h < H_BP + H_VIS &&
          m_row >= V_BP && m_row < V_BP + V_VIS) begin
        p.x = h - H_BP; p.y = m_row - V_BP; p.r = r; p.g = g; p.b = b;
        expq.push_back(p);
        if (p.x == 0 && p.y == 0) fs_expected++;
      end
      drive_sample(h < len - H_SP, !vs_low, r, g, b);
    end
    if (vs_low) m_vseen = 1;
    p_len = len;
    p_full = 1;
    settle_and_check();
  endtask

  // Tail of a vsync line so the first boundary after reset is a frame start.
  task automatic prefix();
    for (int h = WL - H_SP; h < WL; h++) drive_sample(1'b0, 1'b0, 4'h0, 4'h0, 4'h0);
    m_vseen = 1;
    p_full = 0;
    settle_and_check();
  endtask

  task automatic gen_frame(input int nlines, input int special_row, input int special_len,
                           input int rows_emit);
    for (int r = 0; r < rows_emit; r++)
      gen_line((r == special_row) ? special_len : WL, r >= nlines - 2);
  endtask

  task automatic check_reset_outputs();
    check("rst_valid_fs_locked", int'({pixel_valid, frame_start, locked}), 0);
    check("rst_pixel_xy", int'({pixel_x, pixel_y}), 0);
    check("rst_rgb", int'({Red_out, Green_out, Blue_out}), 0);
    check("rst_no_signal", int'(no_signal), 0);
    check("rst_measured", int'({measured_line, measured_frame}), 0);
    check("rst_error_count", int'(error_count), 0);
  endtask

  initial begin
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check_reset_outputs();
    reset = 1'b0;
    model_reset();

    prefix();
    repeat (4) gen_frame(WF, -1, 0, WF);
    gen_frame(WF, 5, WL + 1, WF);
    repeat (3) gen_frame(WF, -1, 0, WF);
    gen_frame(WF, 6, 2 * WL + 8, WF);
    repeat (2) gen_frame(WF, -1, 0, WF);
    gen_frame(WF, -1, 0, 8);

    check("drained_before_reset", expq.size(), 0);
    @(posedge clock); #2;
    reset = 1'b1;
    #1;
    check_reset_outputs();
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    model_reset();

    prefix();
    gen_frame(WF - 1, -1, 0, WF - 1);
    repeat (3) gen_frame(WF, -1, 0, WF);
    gen_line(WL, 1'b0);

    repeat (4) begin @(posedge clock); #1; end
    check("queue_empty", expq.size(), 0);
    check("frame_start_count", fs_seen, fs_expected);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
